// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution RAM arbiter.
package conv_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 10;
    localparam int N_REQ      = 3;

    localparam int REQ_HOST  = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_WB    = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req & ~excl at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [N-1:0] cand;

    always_comb begin
        cand  = req & ~excl;
        valid = 1'b0;
        idx   = '0;
        // Walk from farthest to nearest so the closest candidate to ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters, with
// per-grant burst limit, burst lock and read-return routing.
module ram_arbiter #(
    parameter int N_REQ     = conv_pkg::N_REQ,
    parameter int ADDR_W    = conv_pkg::ADDR_W_DEF,
    parameter int DATA_W    = conv_pkg::DATA_W_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic                      busy
);

    import conv_pkg::*;

    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W:0] BURST_LIM = (CNT_W + 1)'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rvalid_q, rvalid_d;

    logic [IW-1:0]    nxt_ptr, pick_ptr, pick_idx;
    logic [N_REQ-1:0] pick_excl, owner_oh;
    logic [CNT_W:0]   cnt_inc;
    logic             pick_vld, own_req, burst_end, release_own;

    // In OWN the pick starts past the owner and skips it, so a released
    // owner can never immediately re-win.
    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .excl  (pick_excl),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        nxt_ptr     = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        own_req     = (state_q == ARB_OWN) && req[owner_q];
        pick_ptr    = (state_q == ARB_OWN) ? nxt_ptr : ptr_q;
        pick_excl   = (state_q == ARB_OWN) ? owner_oh : '0;
        cnt_inc     = {1'b0, cnt_q} + 1'b1;
        burst_end   = cnt_inc >= BURST_LIM;
        release_own = !req[owner_q] || (burst_end && !lock[owner_q] && pick_vld);
    end

    assign ram_en    = own_req;
    assign ram_we    = own_req && we[owner_q];
    assign ram_addr  = addr[owner_q*ADDR_W +: ADDR_W];
    assign ram_wdata = wdata[owner_q*DATA_W +: DATA_W];
    assign gnt       = gnt_q;
    assign busy      = |gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = (|rvalid_q) ? ram_rdata : '0;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        rvalid_d = (own_req && !we[owner_q]) ? owner_oh : '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d         = ARB_OWN;
                    owner_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    cnt_d           = '0;
                end
            end
            ARB_OWN: begin
                if (release_own) begin
                    ptr_d = nxt_ptr;
                    cnt_d = '0;
                    gnt_d = '0;
                    if (pick_vld) begin
                        owner_d         = pick_idx;
                        gnt_d[pick_idx] = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (req[owner_q] && cnt_inc <= BURST_LIM) begin
                    // Saturate so a long locked burst cannot wrap the count.
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 1-cycle-latency RAM model.
module tb_ram_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 10;

    logic            clk, rstn;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
    logic            ram_en, ram_we, busy;
    logic [AW-1:0]   ram_addr;

    logic [DW-1:0]   mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only RAM model: nothing in this bench writes.
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        req  = '0;
        lock = '0;
        we   = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_gnt(input logic [N-1:0] g, input string tag);
        int k = 0;
        while (gnt !== g && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(gnt), 32'(g));
    endtask

    initial begin
        logic [N-1:0] seq [8];
        logic [N-1:0] last;
        int ns, multi, acc, k;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h05] = 10'h007;
        mem[8'h10] = 10'h055;
        ram_rdata = '0;
        addr  = '0;
        wdata = '0;
        req   = '0;
        lock  = '0;
        we    = '0;
        rstn  = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Single read by requester 1
        req = 3'b010;
        addr[1*AW +: AW] = 16'h0005;
        @(negedge clk);
        check("rd_gnt", 32'(gnt), 32'b010);
        check("rd_busy", 32'(busy), 1);
        check("rd_ram_en", 32'(ram_en), 1);
        check("rd_ram_we", 32'(ram_we), 0);
        check("rd_ram_addr", 32'(ram_addr), 32'h5);
        @(negedge clk);
        check("rd_rvalid", 32'(rvalid), 32'b010);
        check("rd_rdata", 32'(rdata), 32'h7);
        req = 3'b000;
        #1;
        check("rd_drop_en", 32'(ram_en), 0);
        @(negedge clk);
        check("rd_rel_gnt", 32'(gnt), 0);
        check("rd_rel_rvalid", 32'(rvalid), 0);

        // Three-way contention, round-robin order
        do_reset();
        req = 3'b111;
        ns = 0; multi = 0; last = '0;
        for (int i = 0; i < 8; i++) seq[i] = '0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) multi++;
            if (gnt != 0 && gnt != last) begin
                if (ns < 8) seq[ns] = gnt;
                ns++;
                last = gnt;
            end
        end
        check("rr_first", 32'(seq[0]), 32'b001);
        check("rr_second", 32'(seq[1]), 32'b010);
        check("rr_third", 32'(seq[2]), 32'b100);
        check("rr_fourth", 32'(seq[3]), 32'b001);
        check("rr_multihot", 32'(multi), 0);

        // Burst limit hands off with no idle cycle
        do_reset();
        req = 3'b011;
        wait_gnt(3'b001, "burst_gnt0");
        acc = 0; k = 0;
        while (gnt == 3'b001 && k < 40) begin
            if (ram_en) acc++;
            @(negedge clk);
            k++;
        end
        check("burst_count", 32'(acc), 16);
        check("burst_handoff", 32'(gnt), 32'b010);

        // Lock overrides the burst limit
        do_reset();
        req  = 3'b011;
        lock = 3'b001;
        wait_gnt(3'b001, "lock_gnt0");
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (gnt == 3'b001 && ram_en) acc++;
            @(negedge clk);
        end
        check("lock_count", 32'(acc), 40);
        check("lock_still_own", 32'(gnt), 32'b001);
        req  = 3'b010;
        lock = 3'b000;
        #1;
        check("lock_drop_en", 32'(ram_en), 0);
        @(negedge clk);
        check("lock_handoff", 32'(gnt), 32'b010);

        // Read in last owned cycle returns after gnt has moved
        do_reset();
        req = 3'b100;
        addr[2*AW +: AW] = 16'h0010;
        addr[0*AW +: AW] = 16'h0020;
        wait_gnt(3'b100, "ho_gnt2");
        req = 3'b101;
        k = 0;
        while (gnt == 3'b100 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ho_new_gnt", 32'(gnt), 32'b001);
        check("ho_rvalid", 32'(rvalid), 32'b100);
        check("ho_rdata", 32'(rdata), 32'h55);

        // Reset during a read burst
        do_reset();
        req = 3'b001;
        addr[0*AW +: AW] = 16'h0005;
        wait_gnt(3'b001, "mr_gnt0");
        @(negedge clk);
        check("mr_rvalid_pre", 32'(rvalid), 32'b001);
        rstn = 1'b0;
        #1;
        check("mr_gnt", 32'(gnt), 0);
        check("mr_rvalid", 32'(rvalid), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_ram_en", 32'(ram_en), 0);
        @(negedge clk);
        check("mr_rvalid_hold", 32'(rvalid), 0);
        @(negedge clk);
        req  = 3'b100;
        rstn = 1'b1;
        @(negedge clk);
        check("mr_regrant", 32'(gnt), 32'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (0 = host loader, 1 = convolution fetch, 2 = result write-back).
REQ-002 SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-003 SHALL have parameter DATA_W, default 10, RAM data width.
REQ-004 SHALL have parameter MAX_BURST, default 16, accesses per grant before forced release.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req  input  N_REQ  per-requester access request, level.
REQ-008 SHALL have port lock  input  N_REQ  per-requester burst lock; suppresses the MAX_BURST release.
REQ-009 SHALL have port we  input  N_REQ  per-requester write strobe.
REQ-010 SHALL have port addr  input  N_REQ*ADDR_W  packed per-requester addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port wdata  input  N_REQ*DATA_W  packed per-requester write data.
REQ-012 SHALL have port gnt  output  N_REQ  one-hot grant, registered.
REQ-013 SHALL have port rvalid  output  N_REQ  read-data-valid for the requester that issued the read.
REQ-014 SHALL have port rdata  output  DATA_W  shared read data, qualified by rvalid.
REQ-015 SHALL have ports ram_en, ram_we (output 1), ram_addr (output ADDR_W), ram_wdata (output DATA_W), ram_rdata (input DATA_W): single-port RAM side, 1-cycle read latency.
REQ-016 SHALL have port busy  output  1  high while any grant is held.

Function
REQ-017 SHALL implement an FSM with states IDLE and OWN, plus registered owner index, round-robin pointer ptr, and access counter cnt (width clog2(MAX_BURST)+1).
REQ-018 IDLE: at an edge with req!=0, SHALL select the winner as the first set req bit searching upward from ptr, wrapping; SHALL enter OWN with gnt[winner]=1 from the next cycle and cnt=0.
REQ-019 OWN: each cycle with req[owner]=1 SHALL drive ram_en=1, ram_we=we[owner], ram_addr=addr[owner], ram_wdata=wdata[owner] combinationally, and SHALL increment cnt at the edge.
REQ-020 ram_en and ram_we SHALL be 0 in IDLE and in OWN cycles with req[owner]=0.
REQ-021 A read issued in cycle t SHALL return rdata=ram_rdata with rvalid[owner at t]=1 in cycle t+1 only; rvalid SHALL be zero-or-one-hot.
REQ-022 Release SHALL occur at an edge in OWN when req[owner]=0, or when cnt+1 reaches MAX_BURST for the current access, lock[owner]=0 and another req bit is set.
REQ-023 On release, ptr SHALL become owner+1 mod N_REQ; if any other requester (owner excluded) has req=1, the FSM SHALL stay in OWN with the new winner (no idle cycle), else go to IDLE.
REQ-024 With lock[owner]=1, MAX_BURST SHALL be ignored; release only on req drop.
REQ-025 A burst-limited owner still requesting SHALL lose gnt for at least one grant period and compete again via round-robin.
REQ-026 A read in the last owned cycle SHALL still deliver its rvalid the following cycle even though gnt has moved.
REQ-027 gnt SHALL never have more than one bit set; busy SHALL equal |gnt.
REQ-028 Requesters SHALL hold addr/we/wdata stable only while gnt[i]&req[i]; inputs of non-owners SHALL be ignored.

Reset
REQ-029 While rstn=0 (asynchronous), SHALL force state=IDLE, gnt=0, rvalid=0, rdata=0, busy=0, ptr=0, cnt=0, owner=0; ram_en=ram_we=0 combinationally.
REQ-030 Reset mid-burst SHALL discard any in-flight read return; the first grant after release SHALL follow REQ-018 from ptr=0.

Structure
REQ-031 The shared package conv_pkg SHALL hold ADDR_W/DATA_W defaults, N_REQ, requester index constants (REQ_HOST, REQ_FETCH, REQ_WB) and the arbiter state enum.
REQ-032 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs req vector, ptr, exclude mask; outputs valid, index).

Verification
REQ-033 Single read: reset, req=3'b010, addr[1]=0x0005, RAM holds 0x07 at 0x0005 -> gnt=3'b010 one cycle later, ram_addr=0x0005 while req held, rvalid=3'b010 with rdata=0x07 one cycle after each read.
REQ-034 Contention: req=3'b111 from reset, no locks -> grant order 0,1,2,0 across successive releases; gnt never multi-hot.
REQ-035 Burst limit: req=3'b011 held continuously, MAX_BURST=16 -> requester 0 gets exactly 16 ram_en cycles, then gnt switches to 3'b010 at the next edge with no idle cycle.
REQ-036 Lock: as REQ-035 but lock[0]=1 for 40 cycles -> requester 0 keeps gnt for 40 accesses, then releases to requester 1.
REQ-037 Hand-off read: requester 2 reads 0x0010 in its last owned cycle -> rvalid=3'b100 the next cycle while gnt already shows the new owner.
REQ-038 Reset mid-burst: rstn low for 2 cycles during a read -> gnt, rvalid, busy go 0 immediately; after rstn high with req=3'b100, gnt=3'b100 one cycle later.
